// File: rtl/mc_pkg.sv
// Shared encodings and types for the memory-controller command scheduler.
package mc_pkg;

  localparam int MC_AW = 64;
  localparam int PTR_W = 3;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_WR   = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_RD   = 2'd0,
    S_TURN = 2'd1,
    S_WR   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [MC_AW-1:0] addr;
    logic [PTR_W-1:0] ptr;
  } wq_entry_t;

endpackage

// File: rtl/mc_cmd_fifo.sv
// Circular command FIFO with occupancy count; push and pop may occur together.
module mc_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_cmd_sched.sv
// Read/write command scheduler: read priority, write-drain watermarks,
// bus-turnaround bubbles and WDF slot release after each issued write.
//
// state  | meaning
// S_RD   | issuing reads from the read queue head
// S_TURN | turnaround bubble, dir_q holds the direction being entered
// S_WR   | issuing writes from the write queue head
module mc_cmd_sched
  import mc_pkg::*;
#(
  parameter int AW       = 64,
  parameter int RQ_DEPTH = 4,
  parameter int WQ_DEPTH = 8,
  parameter int WR_HI    = 6,
  parameter int WR_LO    = 2,
  parameter int TURN_CYC = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tl_cmd_valid,
  input  logic [1:0]    tl_cmd,
  input  logic [AW-1:0] tl_addr,
  input  logic [2:0]    tl_ptr,
  output logic          tl_cmd_ready,
  output logic          iss_valid,
  output logic [1:0]    iss_cmd,
  output logic [AW-1:0] iss_addr,
  output logic [2:0]    iss_ptr,
  input  logic          iss_ready,
  output logic          wdf_free_valid,
  output logic [2:0]    wdf_free_ptr,
  output logic          cmd_err,
  output logic          sched_mode
);

  localparam int RCW = $clog2(RQ_DEPTH + 1);
  localparam int WCW = $clog2(WQ_DEPTH + 1);
  localparam int TW  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TW-1:0]  TURN_LOAD = TW'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);
  localparam logic [WCW-1:0] WR_HI_C   = WCW'(WR_HI);
  localparam logic [WCW-1:0] WR_LO_C   = WCW'(WR_LO);

  logic            rq_full, rq_empty, wq_full, wq_empty;
  logic [RCW-1:0]  rq_cnt, rq_post;
  logic [WCW-1:0]  wq_cnt, wq_post;
  logic [AW-1:0]   rq_head;
  wq_entry_t       wq_push_data, wq_head;
  logic            push_rd, push_wr, pop_rd, pop_wr, stall;
  logic            go_turn;
  sched_state_e    tgt;

  sched_state_e    state_q, state_d, dir_q, dir_d;
  logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
  logic            wdf_free_valid_q, wdf_free_valid_d;
  logic [2:0]      wdf_free_ptr_q, wdf_free_ptr_d;
  logic            cmd_err_q, cmd_err_d;

  // Readiness uses registered fullness only, so a same-cycle pop never opens room.
  always_comb begin
    case (tl_cmd)
      CMD_WR:           tl_cmd_ready = !wq_full;
      CMD_RD:           tl_cmd_ready = !rq_full;
      CMD_IDLE, CMD_RSVD: tl_cmd_ready = 1'b1;
      default:          tl_cmd_ready = 1'b1;
    endcase
  end

  assign push_rd = tl_cmd_valid && (tl_cmd == CMD_RD) && !rq_full;
  assign push_wr = tl_cmd_valid && (tl_cmd == CMD_WR) && !wq_full;

  assign wq_push_data.addr = MC_AW'(tl_addr);
  assign wq_push_data.ptr  = tl_ptr;

  mc_cmd_fifo #(.WIDTH(AW), .DEPTH(RQ_DEPTH)) u_rq (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_rd),
    .push_data (tl_addr),
    .pop       (pop_rd),
    .head      (rq_head),
    .count     (rq_cnt),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  mc_cmd_fifo #(.WIDTH($bits(wq_entry_t)), .DEPTH(WQ_DEPTH)) u_wq (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_wr),
    .push_data (wq_push_data),
    .pop       (pop_wr),
    .head      (wq_head),
    .count     (wq_cnt),
    .full      (wq_full),
    .empty     (wq_empty)
  );

  assign iss_valid = ((state_q == S_RD) && !rq_empty) || ((state_q == S_WR) && !wq_empty);
  assign stall     = iss_valid && !iss_ready;
  assign pop_rd    = iss_valid && iss_ready && (state_q == S_RD);
  assign pop_wr    = iss_valid && iss_ready && (state_q == S_WR);
  assign rq_post   = rq_cnt - RCW'(pop_rd);
  assign wq_post   = wq_cnt - WCW'(pop_wr);

  always_comb begin
    iss_cmd  = 2'd0;
    iss_addr = '0;
    iss_ptr  = 3'd0;
    if (iss_valid) begin
      if (state_q == S_RD) begin
        iss_cmd  = CMD_RD;
        iss_addr = rq_head;
      end else begin
        iss_cmd  = CMD_WR;
        iss_addr = AW'(wq_head.addr);
        iss_ptr  = wq_head.ptr;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    turn_cnt_d = turn_cnt_q;
    go_turn    = 1'b0;
    tgt        = S_RD;
    case (state_q)
      S_RD: begin
        if (!stall && ((wq_post >= WR_HI_C) || ((rq_post == '0) && (wq_post != '0)))) begin
          go_turn = 1'b1;
          tgt     = S_WR;
        end
      end
      S_WR: begin
        if (!stall && (rq_post != '0) && (wq_post <= WR_LO_C)) begin
          go_turn = 1'b1;
          tgt     = S_RD;
        end
      end
      S_TURN: begin
        if (turn_cnt_q == '0) state_d = dir_q;
        else                  turn_cnt_d = turn_cnt_q - 1'b1;
      end
      default: state_d = S_RD;
    endcase
    if (go_turn) begin
      dir_d = tgt;
      if (TURN_CYC == 0) begin
        state_d = tgt;
      end else begin
        state_d    = S_TURN;
        turn_cnt_d = TURN_LOAD;
      end
    end
  end

  assign wdf_free_valid_d = pop_wr;
  assign wdf_free_ptr_d   = pop_wr ? wq_head.ptr : 3'd0;
  assign cmd_err_d        = tl_cmd_valid && (tl_cmd == CMD_RSVD);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= S_RD;
      dir_q            <= S_RD;
      turn_cnt_q       <= '0;
      wdf_free_valid_q <= 1'b0;
      wdf_free_ptr_q   <= 3'd0;
      cmd_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      dir_q            <= dir_d;
      turn_cnt_q       <= turn_cnt_d;
      wdf_free_valid_q <= wdf_free_valid_d;
      wdf_free_ptr_q   <= wdf_free_ptr_d;
      cmd_err_q        <= cmd_err_d;
    end
  end

  assign wdf_free_valid = wdf_free_valid_q;
  assign wdf_free_ptr   = wdf_free_ptr_q;
  assign cmd_err        = cmd_err_q;
  assign sched_mode     = (state_q == S_WR) || ((state_q == S_TURN) && (dir_q == S_WR));

endmodule

// File: tb/tb_mc_cmd_sched.sv
// Directed bench for mc_cmd_sched: reset, single read/write, watermark drain, full/err, reset mid-drain.
module tb_mc_cmd_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tl_cmd_valid;
  logic [1:0]  tl_cmd;
  logic [63:0] tl_addr;
  logic [2:0]  tl_ptr;
  logic        tl_cmd_ready;
  logic        iss_valid;
  logic [1:0]  iss_cmd;
  logic [63:0] iss_addr;
  logic [2:0]  iss_ptr;
  logic        iss_ready;
  logic        wdf_free_valid;
  logic [2:0]  wdf_free_ptr;
  logic        cmd_err;
  logic        sched_mode;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [2:0]  ptr;
    int          cyc;
  } ent_t;

  ent_t       iss_log[$];
  logic [2:0] free_log[$];

  mc_cmd_sched dut (
    .clk            (clk),
    .rstn           (rstn),
    .tl_cmd_valid   (tl_cmd_valid),
    .tl_cmd         (tl_cmd),
    .tl_addr        (tl_addr),
    .tl_ptr         (tl_ptr),
    .tl_cmd_ready   (tl_cmd_ready),
    .iss_valid      (iss_valid),
    .iss_cmd        (iss_cmd),
    .iss_addr       (iss_addr),
    .iss_ptr        (iss_ptr),
    .iss_ready      (iss_ready),
    .wdf_free_valid (wdf_free_valid),
    .wdf_free_ptr   (wdf_free_ptr),
    .cmd_err        (cmd_err),
    .sched_mode     (sched_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and slot releases are logged mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (rstn && iss_valid && iss_ready)
      iss_log.push_back('{cmd: iss_cmd, addr: iss_addr, ptr: iss_ptr, cyc: cyc});
    if (wdf_free_valid) free_log.push_back(wdf_free_ptr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [63:0] a, input logic [2:0] p);
    tl_cmd_valid = 1'b1;
    tl_cmd       = c;
    tl_addr      = a;
    tl_ptr       = p;
    step();
    tl_cmd_valid = 1'b0;
    tl_cmd       = 2'd0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!iss_valid && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 64'(iss_valid), 64'd1);
  endtask

  // Expected watermark-drain issue order and cycle gaps (2 bubbles per turnaround)
  logic [1:0]  exp_cmd  [9] = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
  logic [63:0] exp_addr [9] = '{64'h100, 64'h200, 64'h201, 64'h202, 64'h203,
                                64'h101, 64'h102, 64'h204, 64'h205};
  logic [2:0]  exp_ptr  [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd4, 3'd5};
  int          exp_gap  [9] = '{0, 3, 1, 1, 1, 3, 1, 3, 1};

  initial begin
    rstn         = 1'b0;
    tl_cmd_valid = 1'b0;
    tl_cmd       = 2'd0;
    tl_addr      = '0;
    tl_ptr       = 3'd0;
    iss_ready    = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_wdf_free",  64'(wdf_free_valid), 64'd0);
    chk("rst_cmd_err",   64'(cmd_err), 64'd0);
    chk("rst_mode",      64'(sched_mode), 64'd0);
    chk("rst_iss_data",  {iss_addr[58:0], iss_cmd, iss_ptr}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tl_cmd = 2'(c);
      #1;
      chk($sformatf("rst_ready_cmd%0d", c), 64'(tl_cmd_ready), 64'd1);
    end
    tl_cmd = 2'd0;
    rstn   = 1'b1;

    // Single read
    iss_ready = 1'b1;
    push_cmd(2'd2, 64'h2, 3'd0);
    chk("rd_valid", 64'(iss_valid), 64'd1);
    chk("rd_cmd",   64'(iss_cmd), 64'd2);
    chk("rd_addr",  iss_addr, 64'h2);
    chk("rd_ptr",   64'(iss_ptr), 64'd0);
    step();
    chk("rd_done",  64'(iss_valid), 64'd0);
    chk("rd_nofree", 64'(wdf_free_valid), 64'd0);

    // Single write with no reads pending: decide, two bubbles, then write mode
    push_cmd(2'd1, 64'h2, 3'd5);
    chk("wr_e0_valid", 64'(iss_valid), 64'd0);
    chk("wr_e0_mode",  64'(sched_mode), 64'd0);
    step();
    chk("wr_turn1_valid", 64'(iss_valid), 64'd0);
    chk("wr_turn1_mode",  64'(sched_mode), 64'd1);
    step();
    chk("wr_turn2_valid", 64'(iss_valid), 64'd0);
    step();
    chk("wr_valid", 64'(iss_valid), 64'd1);
    chk("wr_cmd",   64'(iss_cmd), 64'd1);
    chk("wr_addr",  iss_addr, 64'h2);
    chk("wr_ptr",   64'(iss_ptr), 64'd5);
    step();
    chk("wr_free_valid", 64'(wdf_free_valid), 64'd1);
    chk("wr_free_ptr",   64'(wdf_free_ptr), 64'd5);
    chk("wr_done",       64'(iss_valid), 64'd0);
    step();
    chk("wr_free_once",  64'(wdf_free_valid), 64'd0);
    chk("wr_mode_hold",  64'(sched_mode), 64'd1);

    // Watermark drain
    iss_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) push_cmd(2'd2, 64'h100 + 64'(i), 3'd0);
    for (int i = 0; i < 6; i++) push_cmd(2'd1, 64'h200 + 64'(i), 3'(i));
    step();
    step();
    chk("wm_stall_head", iss_addr, 64'h100);
    iss_log.delete();
    free_log.delete();
    iss_ready = 1'b1;
    begin
      int n = 0;
      while ((iss_log.size() < 9 || free_log.size() < 6) && n < 80) begin
        step();
        n++;
      end
    end
    chk("wm_iss_count",  64'(iss_log.size()), 64'd9);
    chk("wm_free_count", 64'(free_log.size()), 64'd6);
    for (int i = 0; i < 9; i++) begin
      if (i < iss_log.size()) begin
        chk($sformatf("wm_cmd%0d", i),  64'(iss_log[i].cmd), 64'(exp_cmd[i]));
        chk($sformatf("wm_addr%0d", i), iss_log[i].addr, exp_addr[i]);
        chk($sformatf("wm_ptr%0d", i),  64'(iss_log[i].ptr), 64'(exp_ptr[i]));
        if (i > 0)
          chk($sformatf("wm_gap%0d", i), 64'(iss_log[i].cyc - iss_log[i-1].cyc), 64'(exp_gap[i]));
      end
    end
    for (int i = 0; i < 6; i++)
      if (i < free_log.size()) chk($sformatf("wm_free%0d", i), 64'(free_log[i]), 64'(i));

    // Write queue full, reserved and idle commands
    iss_ready = 1'b0;
    do_reset();
    push_cmd(2'd1, 64'h300, 3'd0);
    wait_valid("full_enter_wr", 10);
    chk("full_mode", 64'(sched_mode), 64'd1);
    for (int i = 1; i < 8; i++) push_cmd(2'd1, 64'h300 + 64'(i), 3'(i));
    tl_cmd = 2'd1;
    #1;
    chk("full_ready_wr", 64'(tl_cmd_ready), 64'd0);
    tl_cmd = 2'd2;
    #1;
    chk("full_ready_rd", 64'(tl_cmd_ready), 64'd1);
    push_cmd(2'd3, 64'hdead, 3'd7);
    chk("err_pulse", 64'(cmd_err), 64'd1);
    step();
    chk("err_once", 64'(cmd_err), 64'd0);
    push_cmd(2'd0, 64'hbeef, 3'd6);
    chk("idle_no_err", 64'(cmd_err), 64'd0);
    chk("err_head_addr", iss_addr, 64'h300);
    chk("err_head_ptr",  64'(iss_ptr), 64'd0);
    tl_cmd = 2'd1;
    #1;
    chk("err_still_full", 64'(tl_cmd_ready), 64'd0);
    tl_cmd = 2'd0;

    // Reset in the middle of a write drain, with a handshake on offer
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(2'd1, 64'h400 + 64'(i), 3'(i));
    wait_valid("mid_enter_wr", 10);
    free_log.delete();
    iss_log.delete();
    iss_ready = 1'b1;
    rstn      = 1'b0;
    step();
    rstn = 1'b1;
    chk("mid_valid", 64'(iss_valid), 64'd0);
    chk("mid_mode",  64'(sched_mode), 64'd0);
    chk("mid_free",  64'(wdf_free_valid), 64'd0);
    for (int i = 0; i < 6; i++) step();
    chk("mid_empty_valid", 64'(iss_valid), 64'd0);
    chk("mid_no_iss",  64'(iss_log.size()), 64'd0);
    chk("mid_no_free", 64'(free_log.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_cmd_sched.md
Name: mc_cmd_sched

Overview:
- Command scheduler between the transaction layer (TL) and the DRAM command sequencer.
- Accepts read/write commands from TL, each write tagged with the write-data-FIFO (WDF) slot pointer TL allocated.
- Queues reads and writes separately and issues them with read priority, a write-drain watermark and bus-turnaround bubbles.
- Returns the WDF slot pointer once a write has been issued.

Parameters:
- AW, 64, address width
- RQ_DEPTH, 4, read queue entries (power of 2)
- WQ_DEPTH, 8, write queue entries; equals WDF slot count
- WR_HI, 6, write-queue count at or above which draining starts
- WR_LO, 2, write-queue count at or below which draining may stop
- TURN_CYC, 2, idle cycles inserted on each read/write direction change (0 allowed)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- tl_cmd_valid  in  1  TL command present
- tl_cmd  in  2  0 idle, 1 write, 2 read, 3 reserved
- tl_addr  in  AW  command address
- tl_ptr  in  3  WDF slot of write data (writes only)
- tl_cmd_ready  out  1  command accepted when valid&&ready
- iss_valid  out  1  command offered to sequencer
- iss_cmd  out  2  1 write, 2 read
- iss_addr  out  AW  issued address
- iss_ptr  out  3  WDF slot (writes; 0 for reads)
- iss_ready  in  1  sequencer accepts
- wdf_free_valid  out  1  slot-release pulse
- wdf_free_ptr  out  3  released slot
- cmd_err  out  1  one-cycle pulse, reserved cmd received
- sched_mode  out  1  0 read mode, 1 write mode (TURN reports target direction)

Behaviour:
- Clock, reset and polarity are fixed: one clock `clk`; reset `rstn` is synchronous and active-low.
- Reset (rstn=0 sampled at edge):
  - Both queues flushed; state RD; turn counter 0.
  - Outputs iss_valid, wdf_free_valid, cmd_err, sched_mode are 0; iss_* data is 0.
  - Flushed writes produce no wdf_free pulse.
  - Reset mid-handshake drops the offered command.
- tl_cmd_ready (combinational from registered counts):
  - cmd=1: !wq_full
  - cmd=2: !rq_full
  - cmd=0 or 3: 1
- Push at the accepting edge. Full is evaluated before any same-cycle pop, so no push into a full queue.
- cmd=3 accepted: not queued; cmd_err=1 in the following cycle.
- cmd=0 with valid is ignored.
- Issue:
  - iss_valid=1 in RD when rq non-empty, in WR when wq non-empty; 0 in TURN.
  - iss_* reflects the queue head.
  - Pop on iss_valid&&iss_ready.
  - While iss_valid&&!iss_ready, iss_* and state are held stable ("stalled").
- State machine {RD, TURN, WR}, evaluated each unstalled cycle on post-pop counts:
  - RD→TURN(dir=WR) if wq_cnt>=WR_HI, or (rq empty and wq non-empty).
  - WR→TURN(dir=RD) if rq non-empty and (wq_cnt<=WR_LO or wq empty).
  - Otherwise WR stays and keeps writing.
  - TURN counts TURN_CYC cycles, then enters dir. With TURN_CYC=0, RD↔WR switch directly.
  - A switch decided in the same cycle as a pop applies from the next cycle.
- Write release: one cycle after a write handshake, wdf_free_valid=1 and wdf_free_ptr=issued ptr. Back-to-back writes give consecutive pulses.
- Read and write queues are each FIFO-ordered; no reordering within a direction.
- Simultaneous push and pop on the same queue: count unchanged, both take effect.

Decomposition:
- mc_pkg holds:
  - cmd encoding constants CMD_IDLE/CMD_WR/CMD_RD/CMD_RSVD
  - sched state enum {S_RD, S_TURN, S_WR}
  - write-entry struct {addr, ptr}
- Sub-module mc_cmd_fifo:
  - parameterised width/depth, count, full/empty, same-cycle push+pop.
  - Instantiated twice: reads use addr, writes use the struct.

Test Plan:
- Reset: hold rstn=0 2 cycles -> all outputs 0, tl_cmd_ready=1 for every cmd, sched_mode=0.
- Single read: cmd=2 addr=0x2, iss_ready=1 -> iss_valid next cycle with iss_cmd=2, iss_addr=0x2, iss_ptr=0; single-cycle handshake; no wdf_free.
- Single write, no reads: cmd=1 addr=0x2 ptr=5, iss_ready=1 -> TURN for 2 cycles, iss_valid 3 cycles after the accepting edge (iss_cmd=1, ptr=5); wdf_free_valid=1 with ptr=5 the cycle after the handshake; sched_mode=1.
- Watermark: iss_ready=0, queue reads A0,A1,A2 then writes ptrs 0..5; raise iss_ready -> order is A0, turn, W0..W3 (count reaches 2), turn, A1, A2, turn, W4, W5; wdf_free pulses ptrs 0..5 in order.
- Full/err: iss_ready=0 in WR mode, push 8 writes -> tl_cmd_ready=0 for cmd=1, 1 for cmd=2; cmd=3 -> cmd_err one cycle later, no queue change.
- Reset mid-drain: rstn=0 for one edge in WR with 4 writes queued -> next cycle iss_valid=0, state RD, queues empty, no wdf_free pulses.
